// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the Mini-MIPS datapath: fetch, decode, execute, mul-wait, memory, commit.
// Latency: 4 cycles ALU/branch/jump, 5 cycles lw/sw, 4+MUL_LATENCY cycles mul/madd (zero-wait acks).
// Backpressure: FETCH holds imem_req until imem_ack and MEM holds dmem_req/dmem_we until dmem_ack; no timeout.
module multicycle_sequencer #(
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             branch_taken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write_en,
    output logic             fp_reg_write_en,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MULWAIT = 3'd3,
        S_MEM     = 3'd4,
        S_COMMIT  = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b001001;
    localparam logic [5:0] OP_SW    = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b010001;
    localparam logic [5:0] OP_JAL   = 6'b010010;
    localparam logic [5:0] OP_MFC1  = 6'b011000;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MUL   = 6'b001100;
    localparam logic [5:0] FN_MADD  = 6'b001101;

    state_t           cur;
    logic [5:0]       op_q;
    logic [5:0]       fn_q;
    logic [3:0]       mul_cnt;
    logic [CNT_W-1:0] count_q;

    // Decode of the latched instruction; everything past DECODE works from these.
    logic op_legal, is_rtype, is_jr, is_mul, is_mem, is_sw, is_branch, is_jump;
    logic wr_int, wr_fp;

    always_comb begin
        op_legal  = (op_q <= 6'd18) || ((op_q >= 6'd24) && (op_q <= 6'd33));
        is_rtype  = (op_q == OP_RTYPE);
        is_jr     = is_rtype && (fn_q == FN_JR);
        is_mul    = is_rtype && ((fn_q == FN_MUL) || (fn_q == FN_MADD));
        is_sw     = (op_q == OP_SW);
        is_mem    = (op_q == OP_LW) || is_sw;
        is_branch = (op_q >= 6'd11) && (op_q <= 6'd16);
        is_jump   = (op_q == OP_J) || (op_q == OP_JAL);
        wr_int    = (is_rtype && !is_jr) || ((op_q >= 6'd1) && (op_q <= 6'd9))
                    || (op_q == OP_JAL) || (op_q == OP_MFC1);
        wr_fp     = (op_q == 6'd25) || (op_q == 6'd26) || (op_q == 6'd27) || (op_q == 6'd33);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur     <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            mul_cnt <= '0;
            count_q <= '0;
        end else begin
            case (cur)
                S_FETCH: begin
                    if (imem_ack) cur <= S_DECODE;
                end
                S_DECODE: begin
                    op_q <= opcode;
                    fn_q <= funct;
                    cur  <= (opcode == OP_HALT) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    if (op_legal && is_mul) begin
                        cur     <= S_MULWAIT;
                        mul_cnt <= 4'(MUL_LATENCY - 1);
                    end else if (op_legal && is_mem) begin
                        cur <= S_MEM;
                    end else begin
                        cur <= S_COMMIT;
                    end
                end
                S_MULWAIT: begin
                    if (mul_cnt == 4'd0) cur <= S_COMMIT;
                    else                 mul_cnt <= mul_cnt - 4'd1;
                end
                S_MEM: begin
                    if (dmem_ack) cur <= S_COMMIT;
                end
                S_COMMIT: begin
                    count_q <= count_q + CNT_W'(1);
                    cur     <= S_FETCH;
                end
                S_HALT:  cur <= S_HALT;
                default: cur <= S_FETCH;
            endcase
        end
    end

    // Outputs are gated by rst so a pending request drops in the same cycle reset is asserted.
    always_comb begin
        imem_req        = 1'b0;
        ir_write        = 1'b0;
        dmem_req        = 1'b0;
        dmem_we         = 1'b0;
        reg_write_en    = 1'b0;
        fp_reg_write_en = 1'b0;
        pc_write        = 1'b0;
        pc_src          = 2'd0;
        halted          = 1'b0;
        illegal_op      = 1'b0;
        state           = 3'd0;
        instr_count     = '0;
        if (rst) begin
            state       = cur;
            instr_count = count_q;
            case (cur)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ack;
                end
                S_EXEC: illegal_op = !op_legal;
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_sw;
                end
                S_COMMIT: begin
                    pc_write        = 1'b1;
                    reg_write_en    = op_legal && wr_int;
                    fp_reg_write_en = op_legal && wr_fp;
                    if (op_legal && is_jr)                       pc_src = 2'd3;
                    else if (op_legal && is_jump)                pc_src = 2'd2;
                    else if (op_legal && is_branch && branch_taken) pc_src = 2'd1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
